zone_alarm_ctrl: RTL and testbench
==================================

// Module: zone_alarm_ctrl
// PURPOSE
//  Parametrised multi-zone security controller; replaces per-sensor fire/door/window blocks.
//  Per-zone debounce. Global arm FSM with entry delay on selected zones. Latched per-zone
//  alarms with acknowledge. Fire zone is always armed. Feeds siren driver and status panel.
// PARAMETERS
//  NUM_ZONES    4   number of sensor zones (>=2)
//  DEBOUNCE     3   consecutive cycles a sensor must differ before zone_state follows (>=1)
//  ENTRY_DELAY  16  cycles from entry-zone trip to alarm while armed (>=2)
//  FIRE_ZONE    0   zone index treated as fire: ignores flag, no entry delay
// PORTS
//  clock        in   1          rising-edge clock
//  reset        in   1          synchronous, active-high
//  flag         in   1          1 = disarmed (non-fire alarms suppressed), 0 = armed
//  ack          in   1          acknowledge; clears latched alarms (rules below)
//  sensor       in   NUM_ZONES  raw sensor levels, 1 = tripped
//  entry_mask   in   NUM_ZONES  1 = zone uses entry delay; bit FIRE_ZONE ignored
//  zone_state   out  NUM_ZONES  debounced sensor levels
//  alarm        out  NUM_ZONES  latched per-zone alarms
//  fire_alarm   out  1          alarm[FIRE_ZONE]
//  siren        out  1          |alarm, registered
//  arm_state    out  2          FSM state: 0 DISARMED, 1 ARMED, 2 ENTRY, 3 ALARM
//  entry_count  out  $clog2(ENTRY_DELAY)  remaining entry cycles; 0 outside ENTRY
//  parity       out  1          see CONFIGURATION
// BEHAVIOUR
//  Reset: all outputs, debounce counters and FSM clear to 0 (DISARMED); reset mid-ENTRY/ALARM aborts it.
//  Debounce per zone: cnt++ each cycle sensor!=zone_state, cnt<=0 when equal.
//   If cnt==DEBOUNCE-1 and still differs: zone_state<=sensor, cnt<=0.
//   Latency: DEBOUNCE cycles from stable change to zone_state edge. Glitch shorter than that: no change.
//  Fire zone: zone_state[FIRE_ZONE]=1 sets alarm[FIRE_ZONE] next cycle in any FSM state and any flag.
//  Non-fire zones (trip = zone_state bit high, mask bits not FIRE_ZONE):
//   DISARMED: no latching. flag==0 -> ARMED.
//   ARMED: flag==1 -> DISARMED (priority over a trip in the same cycle).
//    Trip on non-entry zone -> ALARM, that alarm bit set.
//    Trip only on entry zones -> ENTRY; entry_count<=ENTRY_DELAY-1; record pending zones.
//   ENTRY: entry_count-- each cycle. Pending |= newly tripped entry zones.
//    flag==1 before expiry -> DISARMED, pending cleared, nothing latched.
//    Non-entry trip -> ALARM immediately; that bit plus pending latched.
//    entry_count==0 with flag==0 -> ALARM; pending latched.
//   ALARM: siren held. New trips keep latching while flag==0.
//    flag==1 && ack==1 -> DISARMED, non-fire alarm bits cleared. flag==1 alone: stay in ALARM.
//  Fire latch: cleared by ack only when zone_state[FIRE_ZONE]==0; with fire still active, ack has no effect on it.
//  siren and fire_alarm update one cycle after alarm changes. arm_state is registered FSM state.
// CONFIGURATION
//  ZONE_PARITY_EN defined: parity = registered XOR of alarm vector, one cycle after alarm.
//  Not defined: parity tied 0; no parity logic.
// TESTING (NUM_ZONES=4, DEBOUNCE=3, ENTRY_DELAY=8, FIRE_ZONE=0, entry_mask=4'b0010)
//  1. sensor[2] pulse 2 cycles, flag=0, armed -> zone_state stays 0, alarm=0.
//  2. flag=0, sensor[2]=1 held -> zone_state[2]=1 after 3 cycles; arm_state=3; alarm=4'b0100; siren=1 next cycle.
//  3. Armed, sensor[1]=1 held -> ENTRY, entry_count 7..0; flag=1 at count 3 -> DISARMED, alarm=0.
//  4. As 3 with no flag -> ALARM at count 0, alarm=4'b0010; flag=1+ack=1 -> arm_state=0, alarm=0.
//  5. flag=1, sensor[0]=1 -> alarm=4'b0001, fire_alarm=1. ack while sensor high: no change.
//     Drop sensor, wait 3 cycles, ack -> alarm=0.
//  6. ZONE_PARITY_EN, alarm=4'b0101 -> parity=0; alarm=4'b0111 -> parity=1. Macro off -> parity=0.

Source files
------------

// File: rtl/zone_alarm_if.sv
// zone_alarm_if
//   Bundles the control inputs and status outputs of zone_alarm_ctrl.
//   master: sensor/keypad side, drives flag, ack, sensor and entry_mask and
//           observes the status outputs.
//   slave : the controller itself.
//   Signals:
//     flag        1 = disarmed, 0 = armed
//     ack         alarm acknowledge
//     sensor      raw sensor levels, 1 = tripped
//     entry_mask  1 = zone uses the entry delay
//     zone_state  debounced sensor levels
//     alarm       latched per-zone alarms
//     fire_alarm  registered copy of the fire zone alarm bit
//     siren       registered OR of all alarms
//     arm_state   0 DISARMED, 1 ARMED, 2 ENTRY, 3 ALARM
//     entry_count remaining entry-delay cycles, 0 outside ENTRY
//     parity      registered XOR of alarm vector (when enabled)
interface zone_alarm_if #(
    parameter int NUM_ZONES   = 4,
    parameter int ENTRY_DELAY = 16
);
    localparam int CW = $clog2(ENTRY_DELAY);

    logic                 flag;
    logic                 ack;
    logic [NUM_ZONES-1:0] sensor;
    logic [NUM_ZONES-1:0] entry_mask;
    logic [NUM_ZONES-1:0] zone_state;
    logic [NUM_ZONES-1:0] alarm;
    logic                 fire_alarm;
    logic                 siren;
    logic [1:0]           arm_state;
    logic [CW-1:0]        entry_count;
    logic                 parity;

    modport master (
        output flag, ack, sensor, entry_mask,
        input  zone_state, alarm, fire_alarm, siren, arm_state, entry_count, parity
    );

    modport slave (
        input  flag, ack, sensor, entry_mask,
        output zone_state, alarm, fire_alarm, siren, arm_state, entry_count, parity
    );
endinterface

// File: rtl/zone_alarm_ctrl.sv
// zone_alarm_ctrl
//   Multi-zone security controller: per-zone debounce, global arm FSM with an
//   entry delay on selected zones, latched per-zone alarms with acknowledge.
//   The fire zone is always armed and never uses the entry delay.
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous, active-high; clears all state and outputs
//     bus    zone_alarm_if.slave (flag, ack, sensor, entry_mask in;
//            zone_state, alarm, fire_alarm, siren, arm_state, entry_count,
//            parity out)
//   Build option:
//     ZONE_PARITY_EN  when defined, parity is the registered XOR of the alarm
//                     vector; otherwise parity is tied to 0.
module zone_alarm_ctrl #(
    parameter int NUM_ZONES   = 4,
    parameter int DEBOUNCE    = 3,
    parameter int ENTRY_DELAY = 16,
    parameter int FIRE_ZONE   = 0
) (
    input logic         clock,
    input logic         reset,
    zone_alarm_if.slave bus
);
    localparam int CW = $clog2(ENTRY_DELAY);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [NUM_ZONES-1:0] FIRE_MASK = NUM_ZONES'(1) << FIRE_ZONE;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        ENTRY    = 2'd2,
        ALARM    = 2'd3
    } arm_t;

    logic [DW-1:0]        db_cnt [NUM_ZONES];
    logic [NUM_ZONES-1:0] zs;
    arm_t                 state, nxt_state;
    logic [CW-1:0]        cnt, nxt_cnt;
    logic [NUM_ZONES-1:0] pend, nxt_pend;
    logic [NUM_ZONES-1:0] alarm_q, nxt_alarm;
    logic [NUM_ZONES-1:0] set_nf;
    logic                 clr_nf;
    logic                 nxt_fire;
    logic [NUM_ZONES-1:0] trip, emask, trip_entry, trip_direct;
    logic                 siren_q, fire_q;

    // Debounce: zone_state follows sensor after DEBOUNCE consecutive differing cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ZONES; i++) db_cnt[i] <= '0;
            zs <= '0;
        end else begin
            for (int i = 0; i < NUM_ZONES; i++) begin
                if (bus.sensor[i] == zs[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE - 1)) begin
                    zs[i]     <= bus.sensor[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Trip classification; the fire zone is excluded from the arm FSM entirely
    assign trip        = zs & ~FIRE_MASK;
    assign emask       = bus.entry_mask & ~FIRE_MASK;
    assign trip_entry  = trip & emask;
    assign trip_direct = trip & ~emask;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = '0;
        nxt_pend  = '0;
        set_nf    = '0;
        clr_nf    = 1'b0;
        unique case (state)
            DISARMED: begin
                if (!bus.flag) nxt_state = ARMED;
            end
            ARMED: begin
                // Disarm wins over a trip seen in the same cycle
                if (bus.flag) begin
                    nxt_state = DISARMED;
                end else if (|trip_direct) begin
                    nxt_state = ALARM;
                    set_nf    = trip_direct;
                end else if (|trip_entry) begin
                    nxt_state = ENTRY;
                    nxt_cnt   = CW'(ENTRY_DELAY - 1);
                    nxt_pend  = trip_entry;
                end
            end
            ENTRY: begin
                if (bus.flag) begin
                    nxt_state = DISARMED;
                end else if (|trip_direct) begin
                    nxt_state = ALARM;
                    set_nf    = trip_direct | pend | trip_entry;
                end else if (cnt == '0) begin
                    nxt_state = ALARM;
                    set_nf    = pend | trip_entry;
                end else begin
                    nxt_cnt  = cnt - CW'(1);
                    nxt_pend = pend | trip_entry;
                end
            end
            ALARM: begin
                if (bus.flag && bus.ack) begin
                    nxt_state = DISARMED;
                    clr_nf    = 1'b1;
                end else if (!bus.flag) begin
                    set_nf = trip;
                end
            end
            default: nxt_state = DISARMED;
        endcase

        // Fire latch: active fire always wins over ack
        if (zs[FIRE_ZONE])  nxt_fire = 1'b1;
        else if (bus.ack)   nxt_fire = 1'b0;
        else                nxt_fire = alarm_q[FIRE_ZONE];

        nxt_alarm = (clr_nf ? '0 : ((alarm_q | set_nf) & ~FIRE_MASK))
                  | (nxt_fire ? FIRE_MASK : '0);
    end

    // State, latched alarms and derived registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= DISARMED;
            cnt     <= '0;
            pend    <= '0;
            alarm_q <= '0;
            siren_q <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            pend    <= nxt_pend;
            alarm_q <= nxt_alarm;
            siren_q <= |alarm_q;
            fire_q  <= alarm_q[FIRE_ZONE];
        end
    end

`ifdef ZONE_PARITY_EN
    logic parity_q;
    always_ff @(posedge clock) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= ^alarm_q;
    end
    assign bus.parity = parity_q;
`else
    assign bus.parity = 1'b0;
`endif

    assign bus.zone_state  = zs;
    assign bus.alarm       = alarm_q;
    assign bus.fire_alarm  = fire_q;
    assign bus.siren       = siren_q;
    assign bus.arm_state   = state;
    assign bus.entry_count = cnt;
endmodule

// File: tb/tb_zone_alarm_ctrl.sv
// tb_zone_alarm_ctrl
//   Scoreboard bench for zone_alarm_ctrl with NUM_ZONES=4, DEBOUNCE=3,
//   ENTRY_DELAY=8, FIRE_ZONE=0, entry_mask=4'b0010. Expected values are
//   queued with the cycle they are due and compared on the falling edge.
module tb_zone_alarm_ctrl;
    localparam int NZ = 4;
    localparam int ED = 8;
    localparam int SEL_ZONE = 0, SEL_ALARM = 1, SEL_FIRE = 2, SEL_SIREN = 3,
                   SEL_ARM = 4, SEL_CNT = 5, SEL_PAR = 6;
`ifdef ZONE_PARITY_EN
    localparam logic PAR_0111 = 1'b1;
`else
    localparam logic PAR_0111 = 1'b0;
`endif

    typedef struct {
        int          due;
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   base = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    zone_alarm_if #(.NUM_ZONES(NZ), .ENTRY_DELAY(ED)) bus ();

    zone_alarm_ctrl #(
        .NUM_ZONES(NZ), .DEBOUNCE(3), .ENTRY_DELAY(ED), .FIRE_ZONE(0)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            SEL_ZONE:  return 32'(bus.zone_state);
            SEL_ALARM: return 32'(bus.alarm);
            SEL_FIRE:  return 32'(bus.fire_alarm);
            SEL_SIREN: return 32'(bus.siren);
            SEL_ARM:   return 32'(bus.arm_state);
            SEL_CNT:   return 32'(bus.entry_count);
            default:   return 32'(bus.parity);
        endcase
    endfunction

    task automatic exp_at(input int d, input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.due = base + d;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic goto(input int d);
        while (cyc < base + d) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pop every expectation due this cycle and compare it
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                chk(sb[i].tag, sample(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.flag       = 1'b1;
        bus.ack        = 1'b0;
        bus.sensor     = '0;
        bus.entry_mask = 4'b0010;
        base = 0;
        goto(2);

        // Reset state
        base = cyc;
        exp_at(0, "rst_alarm", SEL_ALARM, 0);
        exp_at(0, "rst_arm",   SEL_ARM,   0);
        exp_at(0, "rst_siren", SEL_SIREN, 0);
        exp_at(0, "rst_cnt",   SEL_CNT,   0);
        exp_at(0, "rst_zone",  SEL_ZONE,  0);
        rst      = 1'b0;
        bus.flag = 1'b0;

        // 1: two-cycle glitch on zone 2 while armed is filtered
        exp_at(1, "t1_armed", SEL_ARM, 1);
        goto(1); bus.sensor = 4'b0100;
        goto(3); bus.sensor = 4'b0000;
        exp_at(6, "t1_zone",  SEL_ZONE,  0);
        exp_at(6, "t1_alarm", SEL_ALARM, 0);
        exp_at(6, "t1_arm",   SEL_ARM,   1);
        goto(6);

        // 2: held trip on non-entry zone 2 -> ALARM
        base = cyc;
        bus.sensor = 4'b0100;
        exp_at(2, "t2_zone_lat", SEL_ZONE,  4'b0000);
        exp_at(3, "t2_zone",     SEL_ZONE,  4'b0100);
        exp_at(4, "t2_arm",      SEL_ARM,   3);
        exp_at(4, "t2_alarm",    SEL_ALARM, 4'b0100);
        exp_at(4, "t2_siren_0",  SEL_SIREN, 0);
        exp_at(5, "t2_siren_1",  SEL_SIREN, 1);
        goto(6); bus.flag = 1'b1; bus.ack = 1'b1; bus.sensor = 4'b0000;
        exp_at(7, "t2_clr_arm",   SEL_ARM,   0);
        exp_at(7, "t2_clr_alarm", SEL_ALARM, 0);
        exp_at(8, "t2_clr_siren", SEL_SIREN, 0);
        goto(7); bus.ack = 1'b0;
        goto(11);

        // 3: entry zone trip, disarm at count 3
        base = cyc;
        bus.flag = 1'b0;
        exp_at(1, "t3_armed", SEL_ARM, 1);
        goto(1); bus.sensor = 4'b0010;
        exp_at(5, "t3_entry",  SEL_ARM, 2);
        exp_at(5, "t3_cnt7",   SEL_CNT, 7);
        exp_at(7, "t3_cnt5",   SEL_CNT, 5);
        exp_at(9, "t3_cnt3",   SEL_CNT, 3);
        goto(9); bus.flag = 1'b1; bus.sensor = 4'b0000;
        exp_at(10, "t3_disarm", SEL_ARM,   0);
        exp_at(10, "t3_cnt0",   SEL_CNT,   0);
        exp_at(10, "t3_alarm",  SEL_ALARM, 0);
        goto(13);

        // 4: entry delay expires -> ALARM; flag alone holds, flag+ack clears
        base = cyc;
        bus.flag = 1'b0; bus.sensor = 4'b0010;
        exp_at(4,  "t4_entry",    SEL_ARM,   2);
        exp_at(4,  "t4_cnt7",     SEL_CNT,   7);
        exp_at(11, "t4_cnt0",     SEL_CNT,   0);
        exp_at(11, "t4_still",    SEL_ARM,   2);
        exp_at(12, "t4_alarm_st", SEL_ARM,   3);
        exp_at(12, "t4_alarm",    SEL_ALARM, 4'b0010);
        exp_at(12, "t4_cnt_out",  SEL_CNT,   0);
        exp_at(12, "t4_siren_0",  SEL_SIREN, 0);
        exp_at(13, "t4_siren_1",  SEL_SIREN, 1);
        goto(13); bus.flag = 1'b1; bus.sensor = 4'b0000;
        exp_at(14, "t4_hold_arm",   SEL_ARM,   3);
        exp_at(14, "t4_hold_alarm", SEL_ALARM, 4'b0010);
        goto(14); bus.ack = 1'b1;
        exp_at(15, "t4_ack_arm",   SEL_ARM,   0);
        exp_at(15, "t4_ack_alarm", SEL_ALARM, 0);
        goto(15); bus.ack = 1'b0;
        exp_at(16, "t4_siren_off", SEL_SIREN, 0);
        goto(17);

        // 5: fire zone while disarmed; zone 2 suppressed; ack blocked while fire active
        base = cyc;
        bus.sensor = 4'b0101;
        exp_at(3,  "t5_zone",      SEL_ZONE,  4'b0101);
        exp_at(3,  "t5_alarm_lat", SEL_ALARM, 0);
        exp_at(4,  "t5_alarm",     SEL_ALARM, 4'b0001);
        exp_at(4,  "t5_fire_lat",  SEL_FIRE,  0);
        exp_at(5,  "t5_fire",      SEL_FIRE,  1);
        exp_at(5,  "t5_siren",     SEL_SIREN, 1);
        exp_at(5,  "t5_arm",       SEL_ARM,   0);
        goto(6); bus.ack = 1'b1;
        exp_at(7,  "t5_ack_blk",   SEL_ALARM, 4'b0001);
        goto(7); bus.ack = 1'b0; bus.sensor = 4'b0000;
        exp_at(10, "t5_zone_clr",  SEL_ZONE,  0);
        exp_at(10, "t5_held",      SEL_ALARM, 4'b0001);
        goto(10); bus.ack = 1'b1;
        exp_at(11, "t5_ack_clr",   SEL_ALARM, 0);
        goto(11); bus.ack = 1'b0;
        exp_at(12, "t5_fire_clr",  SEL_FIRE,  0);
        exp_at(12, "t5_siren_clr", SEL_SIREN, 0);
        goto(12);

        // 6: parity over alarm 0101 then 0111; then reset mid-ALARM
        base = cyc;
        bus.flag = 1'b0; bus.sensor = 4'b0101;
        exp_at(4,  "t6_alarm_0101", SEL_ALARM, 4'b0101);
        exp_at(4,  "t6_arm",        SEL_ARM,   3);
        exp_at(5,  "t6_par_0101",   SEL_PAR,   0);
        goto(5); bus.sensor = 4'b0111;
        exp_at(8,  "t6_alarm_hold", SEL_ALARM, 4'b0101);
        exp_at(9,  "t6_alarm_0111", SEL_ALARM, 4'b0111);
        exp_at(10, "t6_par_0111",   SEL_PAR,   32'(PAR_0111));
        goto(10); rst = 1'b1;
        exp_at(11, "t6_rst_arm",   SEL_ARM,   0);
        exp_at(11, "t6_rst_alarm", SEL_ALARM, 0);
        exp_at(11, "t6_rst_siren", SEL_SIREN, 0);
        exp_at(11, "t6_rst_fire",  SEL_FIRE,  0);
        exp_at(11, "t6_rst_zone",  SEL_ZONE,  0);
        goto(11); rst = 1'b0;

        // Drain the scoreboard, bounded
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("sb_drain", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
